// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per enabled clock, saturating quotient.
// Latency N_WIDTH enabled edges (1 for a zero divisor); en=0 freezes everything, start ignored while busy.
module divider_seq #(
  parameter int N_WIDTH = 32,
  parameter int D_WIDTH = 16,
  parameter int Q_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [N_WIDTH-1:0] x1,
  input  logic [D_WIDTH-1:0] x2,
  output logic               busy,
  output logic               done,
  output logic [Q_WIDTH-1:0] y,
  output logic [D_WIDTH-1:0] r,
  output logic               ovf,
  output logic               dz
);

  localparam int CW = $clog2(N_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t             state;
  logic [N_WIDTH-1:0] sreg;
  logic [D_WIDTH-1:0] rem;
  logic [D_WIDTH-1:0] dvs;
  logic [CW-1:0]      cnt;

  logic [D_WIDTH:0]   partial;
  logic [D_WIDTH:0]   diff;
  logic               ge;
  logic [D_WIDTH-1:0] rem_nxt;
  logic [N_WIDTH-1:0] quo_nxt;
  logic               q_hi;

  // partial < 2*divisor always, so the top bit of the difference is the borrow
  always_comb begin
    partial = {rem, sreg[N_WIDTH-1]};
    diff    = partial - {1'b0, dvs};
    ge      = ~diff[D_WIDTH];
    rem_nxt = ge ? diff[D_WIDTH-1:0] : partial[D_WIDTH-1:0];
    quo_nxt = {sreg[N_WIDTH-2:0], ge};
    q_hi    = 1'b0;
    for (int i = Q_WIDTH; i < N_WIDTH; i++) begin
      q_hi = q_hi | quo_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      r     <= '0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (x2 != '0) begin
              sreg  <= x1;
              dvs   <= x2;
              rem   <= '0;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= ZERO;
            end
          end
        end
        RUN: begin
          sreg <= quo_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            y     <= q_hi ? '1 : quo_nxt[Q_WIDTH-1:0];
            r     <= rem_nxt;
            ovf   <= q_hi;
            dz    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ZERO: begin
          y     <= '1;
          r     <= '0;
          ovf   <= 1'b0;
          dz    <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
